// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe board datapath.
// Cell encodings, scanner states and width helpers.
package tictactoe_pkg;

  localparam int CELL_EMPTY = 0;
  localparam int CELL_X     = 1;
  localparam int CELL_O     = 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } scan_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_classify.sv
// Classifies a single board cell encoding.
// Shared by the space scanner and the win detector.
module cell_classify
  import tictactoe_pkg::*;
#(
  parameter int CELL_W = 2
) (
  input  logic [CELL_W-1:0] cell_i,
  output logic              is_empty_o,
  output logic              is_illegal_o
);

  assign is_empty_o   = (int'(cell_i) == CELL_EMPTY);
  assign is_illegal_o = (int'(cell_i) > CELL_O);

endmodule

// File: rtl/board_space_scanner.sv
// Sequential board scanner: one cell per clock over a snapshot,
// reporting free count, first free cell and illegal encodings.
module board_space_scanner
  import tictactoe_pkg::*;
#(
  parameter int BOARD_DIM = 3,
  parameter int CELL_W    = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  input  logic [BOARD_DIM*BOARD_DIM*CELL_W-1:0] board,
  output logic busy,
  output logic done,
  output logic no_space,
  output logic [cnt_width(BOARD_DIM*BOARD_DIM)-1:0] free_count,
  output logic [idx_width(BOARD_DIM*BOARD_DIM)-1:0] first_free,
  output logic has_free,
  output logic illegal
);

  localparam int NCELLS = BOARD_DIM * BOARD_DIM;
  localparam int CNT_W  = cnt_width(NCELLS);
  localparam int IDX_W  = idx_width(NCELLS);
  localparam int BW     = NCELLS * CELL_W;

  scan_state_t state_q, state_d;

  logic [BW-1:0]    snap_q, snap_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_found_q, acc_found_d;
  logic [IDX_W-1:0] acc_first_q, acc_first_d;
  logic             acc_ill_q, acc_ill_d;

  logic             done_q, done_d;
  logic             no_space_q, no_space_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;
  logic [IDX_W-1:0] first_free_q, first_free_d;
  logic             has_free_q, has_free_d;
  logic             illegal_q, illegal_d;

  logic [CELL_W-1:0] cur_cell;
  logic              cur_empty;
  logic              cur_ill;
  logic              last_cell;

  assign cur_cell  = snap_q[int'(idx_q)*CELL_W +: CELL_W];
  assign last_cell = (idx_q == IDX_W'(NCELLS - 1));

  cell_classify #(
    .CELL_W(CELL_W)
  ) u_classify (
    .cell_i      (cur_cell),
    .is_empty_o  (cur_empty),
    .is_illegal_o(cur_ill)
  );

  // Done cycle still counts as busy so a start there is dropped.
  assign busy       = (state_q != IDLE) || done_q;
  assign done       = done_q;
  assign no_space   = no_space_q;
  assign free_count = free_count_q;
  assign first_free = first_free_q;
  assign has_free   = has_free_q;
  assign illegal    = illegal_q;

  // Next-state, accumulator and result-load logic.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    acc_cnt_d    = acc_cnt_q;
    acc_found_d  = acc_found_q;
    acc_first_d  = acc_first_q;
    acc_ill_d    = acc_ill_q;
    done_d       = 1'b0;
    no_space_d   = no_space_q;
    free_count_d = free_count_q;
    first_free_d = first_free_q;
    has_free_d   = has_free_q;
    illegal_d    = illegal_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort && !done_q) begin
          snap_d      = board;
          idx_d       = '0;
          acc_cnt_d   = '0;
          acc_found_d = 1'b0;
          acc_first_d = '0;
          acc_ill_d   = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (cur_empty) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (!acc_found_q) begin
              acc_found_d = 1'b1;
              acc_first_d = idx_q;
            end
          end
          if (cur_ill) acc_ill_d = 1'b1;
          if (last_cell) state_d = REPORT;
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
        if (!abort) begin
          free_count_d = acc_cnt_q;
          first_free_d = acc_found_q ? acc_first_q : '0;
          has_free_d   = acc_found_q;
          no_space_d   = !acc_found_q;
          illegal_d    = acc_ill_q;
          done_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot, accumulator and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      idx_q        <= '0;
      acc_cnt_q    <= '0;
      acc_found_q  <= 1'b0;
      acc_first_q  <= '0;
      acc_ill_q    <= 1'b0;
      done_q       <= 1'b0;
      no_space_q   <= 1'b0;
      free_count_q <= '0;
      first_free_q <= '0;
      has_free_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_found_q  <= acc_found_d;
      acc_first_q  <= acc_first_d;
      acc_ill_q    <= acc_ill_d;
      done_q       <= done_d;
      no_space_q   <= no_space_d;
      free_count_q <= free_count_d;
      first_free_q <= first_free_d;
      has_free_q   <= has_free_d;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_board_space_scanner.sv
// Scoreboard bench for board_space_scanner (3x3 and 4x4).
// Expected results come from a cell-list reference model.
module tb_board_space_scanner;

  typedef struct {
    int cnt;
    int first;
    int found;
    int ill;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  int   ndone3 = 0;
  int   ndone4 = 0;

  logic        rn3, start3, abort3;
  logic [17:0] board3;
  logic        busy3, done3, ns3, hf3, il3;
  logic [3:0]  fc3, ff3;

  logic        rn4, start4, abort4;
  logic [31:0] board4;
  logic        busy4, done4, ns4, hf4, il4;
  logic [4:0]  fc4;
  logic [3:0]  ff4;

  exp_t q3[$];
  exp_t q4[$];

  board_space_scanner #(.BOARD_DIM(3), .CELL_W(2)) dut3 (
    .clk(clk), .reset_n(rn3), .start(start3), .abort(abort3),
    .board(board3), .busy(busy3), .done(done3), .no_space(ns3),
    .free_count(fc3), .first_free(ff3), .has_free(hf3),
    .illegal(il3)
  );

  board_space_scanner #(.BOARD_DIM(4), .CELL_W(2)) dut4 (
    .clk(clk), .reset_n(rn4), .start(start4), .abort(abort4),
    .board(board4), .busy(busy4), .done(done4), .no_space(ns4),
    .free_count(fc4), .first_free(ff4), .has_free(hf4),
    .illegal(il4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endfunction

  function automatic exp_t model(input logic [31:0] b, input int n);
    exp_t e;
    e.cnt = 0; e.first = 0; e.found = 0; e.ill = 0; e.cyc = 0;
    for (int k = 0; k < n; k++) begin
      int v;
      v = int'((b >> (2 * k)) & 32'd3);
      if (v == 0) begin
        e.cnt++;
        if (e.found == 0) begin
          e.found = 1;
          e.first = k;
        end
      end
      if (v > 2) e.ill = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] pack(input int c[16]);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[2*k +: 2] = c[k][1:0];
    return b;
  endfunction

  function automatic logic [31:0] rnd_board();
    logic [31:0] b;
    int r;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      r = int'($urandom_range(0, 9));
      b[2*k +: 2] = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 :
                    (r < 9) ? 2'd2 : 2'd3;
    end
    return b;
  endfunction

  function automatic void cmp(string t, exp_t e, int fc, int ff,
                              int hf, int ns, int il);
    chk({t, "_free_count"}, fc, e.cnt);
    chk({t, "_first_free"}, ff, e.found ? e.first : 0);
    chk({t, "_has_free"}, hf, e.found);
    chk({t, "_no_space"}, ns, e.found ? 0 : 1);
    chk({t, "_illegal"}, il, e.ill);
    chk({t, "_done_cycle"}, cyc, e.cyc);
  endfunction

  // Monitor: pop and compare whenever a scanner reports.
  always @(negedge clk) begin
    if (done3) begin
      ndone3++;
      if (q3.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL dut3_unexpected_done: got done at %0d required none", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        cmp("dut3", e, int'(fc3), int'(ff3), int'(hf3), int'(ns3), int'(il3));
      end
    end
    if (done4) begin
      ndone4++;
      if (q4.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL dut4_unexpected_done: got done at %0d required none", cyc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        cmp("dut4", e, int'(fc4), int'(ff4), int'(hf4), int'(ns4), int'(il4));
      end
    end
  end

  task automatic issue3(input logic [31:0] b);
    exp_t e;
    board3 = b[17:0];
    start3 = 1'b1;
    e = model(b, 9);
    e.cyc = cyc + 11;
    q3.push_back(e);
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic issue4(input logic [31:0] b);
    exp_t e;
    board4 = b;
    start4 = 1'b1;
    e = model(b, 16);
    e.cyc = cyc + 18;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done3(input int budget);
    int n;
    n = 0;
    while (!done3 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done3) begin
      nchk++; nfail++;
      $display("FAIL dut3_timeout: got no done in %0d cycles required done", budget);
    end
  endtask

  task automatic wait_done4(input int budget);
    int n;
    n = 0;
    while (!done4 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done4) begin
      nchk++; nfail++;
      $display("FAIL dut4_timeout: got no done in %0d cycles required done", budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c[16];
    int d;
    exp_t ill_e;
    logic [31:0] b;

    rn3 = 1'b0; start3 = 1'b0; abort3 = 1'b0; board3 = '0;
    rn4 = 1'b0; start4 = 1'b0; abort4 = 1'b0; board4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy3), 0);
    chk("rst_done", int'(done3), 0);
    chk("rst_no_space", int'(ns3), 0);
    chk("rst_free_count", int'(fc3), 0);
    chk("rst_first_free", int'(ff3), 0);
    chk("rst_has_free", int'(hf3), 0);
    chk("rst_illegal", int'(il3), 0);
    rn3 = 1'b1;
    rn4 = 1'b1;
    @(negedge clk);

    issue3(32'd0);
    wait_done3(20);
    @(negedge clk);

    c = '{1, 2, 1, 2, 1, 2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0};
    issue3(pack(c));
    wait_done3(20);
    @(negedge clk);

    c = '{1, 1, 2, 2, 1, 2, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0};
    issue3(pack(c));
    wait_done3(20);
    @(negedge clk);
    c = '{1, 1, 2, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    issue3(pack(c));
    wait_done3(20);
    @(negedge clk);

    c = '{1, 1, 1, 0, 0, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    d = ndone3;
    issue3(pack(c));
    repeat (2) @(negedge clk);
    board3 = '0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_done3(20);
    board3 = 18'h3ffff;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("start_in_done_ignored", int'(busy3), 0);
    repeat (14) @(negedge clk);
    chk("snapshot_single_done", ndone3 - d, 1);

    c = '{2, 1, 2, 1, 1, 0, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    issue3(pack(c));
    wait_done3(20);
    @(negedge clk);
    c = '{2, 1, 2, 1, 1, 3, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    ill_e = model(pack(c), 9);
    issue3(pack(c));
    wait_done3(20);
    @(negedge clk);

    d = ndone3;
    issue3(32'd0);
    void'(q3.pop_back());
    repeat (3) @(negedge clk);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    chk("abort_busy", int'(busy3), 0);
    chk("abort_keep_illegal", int'(il3), ill_e.ill);
    chk("abort_keep_no_space", int'(ns3), 1);
    chk("abort_keep_free_count", int'(fc3), ill_e.cnt);
    repeat (15) @(negedge clk);
    chk("abort_no_done", ndone3 - d, 0);

    abort3 = 1'b1;
    start3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0;
    start3 = 1'b0;
    chk("abort_blocks_start", int'(busy3), 0);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      issue3(rnd_board());
      wait_done3(20);
      @(negedge clk);
    end

    c = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    issue4(pack(c));
    wait_done4(30);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      issue4(rnd_board());
      wait_done4(30);
      @(negedge clk);
    end

    d = ndone4;
    b = 32'h5555_5550;
    issue4(b);
    void'(q4.pop_back());
    repeat (5) @(negedge clk);
    rn4 = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy4), 0);
    chk("rst_mid_free_count", int'(fc4), 0);
    chk("rst_mid_first_free", int'(ff4), 0);
    chk("rst_mid_has_free", int'(hf4), 0);
    chk("rst_mid_no_space", int'(ns4), 0);
    chk("rst_mid_illegal", int'(il4), 0);
    @(negedge clk);
    rn4 = 1'b1;
    repeat (25) @(negedge clk);
    chk("rst_mid_no_done", ndone4 - d, 0);

    chk("dut3_queue_drained", q3.size(), 0);
    chk("dut4_queue_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
